// File: rtl/shifter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shifter_pkg                                                    |
// | Purpose  : Shared constants and FSM state encoding for iter_left_shifter |
// | Revision : 1.0  - initial release                                        |
// +--------------------------------------------------------------------------+
package shifter_pkg;

  // Default operand width and matching shift-amount width (WIDTH = 2**SHAMT_W)
  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  // Shifter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : shift_counter                                                  |
// | Purpose  : Loadable down-counter with zero flag; saturates at zero        |
// | Revision : 1.0  - initial release                                        |
// +--------------------------------------------------------------------------+
module shift_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: load has priority; decrement never goes below zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule : shift_counter
`default_nettype wire

// File: rtl/iter_left_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : iter_left_shifter                                              |
// | Purpose  : Iterative left shifter, one bit per clock, valid/ready ports.  |
// |            Define ITER_SHIFT_OVERFLOW_EN to add the overflow output.     |
// | Revision : 1.0  - initial release                                        |
// +--------------------------------------------------------------------------+
module iter_left_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] shiftamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
`ifdef ITER_SHIFT_OVERFLOW_EN
  output logic               overflow,
`endif
  output logic               busy
);

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   work_q;
  logic [WIDTH-1:0]   work_d;
  logic               cnt_load;
  logic               cnt_dec;
  logic [SHAMT_W-1:0] cnt_value;
  logic               cnt_zero;
  logic               accept;

  // Handshake outputs are pure functions of the current state
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = work_q;
  assign accept    = in_valid && (state_q == IDLE);

  shift_counter #(
    .CNT_W (SHAMT_W)
  ) u_shift_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (shiftamt),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  // Next-state, working-register and counter-control logic
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d   = data;
          cnt_load = 1'b1;
          state_d  = (shiftamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (!cnt_zero) begin
          work_d  = {work_q[WIDTH-2:0], 1'b0};
          cnt_dec = 1'b1;
        end
        // Leave on the edge where the count steps from 1 to 0
        if ((cnt_value == SHAMT_W'(1)) || cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working register, abandoned asynchronously on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
    end
  end

`ifdef ITER_SHIFT_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;

  // Sticky OR of every bit pushed out of the MSB, cleared per request
  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      ovf_d = 1'b0;
    end else if ((state_q == SHIFT) && !cnt_zero) begin
      ovf_d = ovf_q | work_q[WIDTH-1];
    end
  end

  // Overflow flag register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule : iter_left_shifter
`default_nettype wire
